// File: rtl/secuenciador_pkg.sv
// Shared constants, state encoding and decode helpers for the secuenciador
// instruction fetch/issue unit.
package secuenciador_pkg;

    localparam logic [1:0] OP_INM   = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_MOV   = 2'b10;
    localparam logic [1:0] OP_COND  = 2'b11;

    localparam logic [4:0] BUS_LOAD    = 5'b10110;
    localparam logic [7:0] HALT_OP_DEF = 8'hFF;

    typedef enum logic [2:0] {
        REPOSO,
        LEER,
        EMITIR,
        ESPERA_DATOS,
        DETENIDO
    } estado_t;

    function automatic logic es_carga_bus(input logic [7:0] op);
        return op[7:3] == BUS_LOAD;
    endfunction

    function automatic logic es_condicional(input logic [7:0] op);
        return op[7:6] == OP_COND;
    endfunction

endpackage

// File: rtl/secuenciador_memoria_prog.sv
// Program memory: 2^AW bytes, one synchronous write port and one
// synchronous read port with read enable. Contents are never reset.
module memoria_prog #(
    parameter int AW = 6
) (
    input  logic          clck,
    input  logic          we,
    input  logic [AW-1:0] wdir,
    input  logic [7:0]    wdato,
    input  logic          re,
    input  logic [AW-1:0] rdir,
    output logic [7:0]    rdato
);

    logic [7:0] mem [2**AW];

    // Read data is held while re is low so the fetched byte stays stable
    // through EMITIR and any handshake wait.
    always_ff @(posedge clck) begin
        if (we) begin
            mem[wdir] <= wdato;
        end
        if (re) begin
            rdato <= mem[rdir];
        end
    end

endmodule

// File: rtl/secuenciador.sv
// Instruction fetch/issue sequencer: fetches from program memory, issues
// instructions with a one-cycle paso strobe and handles bus-load handshakes.
module secuenciador
    import secuenciador_pkg::*;
#(
    parameter int         AW      = 6,
    parameter logic [7:0] HALT_OP = HALT_OP_DEF
) (
    input  logic          clck,
    input  logic          rst_n,
    input  logic          inicio,
    input  logic          carga_we,
    input  logic [AW-1:0] carga_dir,
    input  logic [7:0]    carga_dato,
    input  logic [7:0]    datos_in,
    input  logic          datos_valid,
    output logic          datos_ready,
    input  logic          flag,
    input  logic [7:0]    alContador,
    output logic [7:0]    instruccion,
    output logic [7:0]    datos,
    output logic          paso,
    output logic [AW-1:0] pc,
    output logic          ocupado,
    output logic          detenido
);

    estado_t       estado, estado_sig;
    logic [AW-1:0] pc_sig;
    logic [7:0]    instr_sig;
    logic [7:0]    datos_sig;
    logic          paso_sig;
    logic          mem_re;
    logic          mem_we;
    logic [7:0]    ir;
    logic          unused_al;

    assign unused_al   = ^alContador;
    assign ocupado     = !(estado == REPOSO || estado == DETENIDO);
    assign detenido    = (estado == DETENIDO);
    assign datos_ready = (estado == ESPERA_DATOS);
    assign mem_we      = carga_we && !ocupado;

    memoria_prog #(.AW(AW)) u_mem (
        .clck  (clck),
        .we    (mem_we),
        .wdir  (carga_dir),
        .wdato (carga_dato),
        .re    (mem_re),
        .rdir  (pc),
        .rdato (ir)
    );

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= REPOSO;
            pc          <= '0;
            instruccion <= '0;
            datos       <= '0;
            paso        <= 1'b0;
        end else begin
            estado      <= estado_sig;
            pc          <= pc_sig;
            instruccion <= instr_sig;
            datos       <= datos_sig;
            paso        <= paso_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        pc_sig     = pc;
        instr_sig  = instruccion;
        datos_sig  = datos;
        paso_sig   = 1'b0;
        mem_re     = 1'b0;
        case (estado)
            REPOSO, DETENIDO: begin
                if (inicio) begin
                    pc_sig     = '0;
                    estado_sig = LEER;
                end
            end
            LEER: begin
                mem_re     = 1'b1;
                estado_sig = EMITIR;
            end
            EMITIR: begin
                if (ir == HALT_OP) begin
                    estado_sig = DETENIDO;
                end else if (es_carga_bus(ir)) begin
                    estado_sig = ESPERA_DATOS;
                end else begin
                    paso_sig   = 1'b1;
                    instr_sig  = ir;
                    estado_sig = LEER;
                    // Conditional jumps take their target from the datapath's R0
                    if (es_condicional(ir) && flag) begin
                        pc_sig = alContador[AW-1:0];
                    end else begin
                        pc_sig = pc + AW'(1);
                    end
                end
            end
            ESPERA_DATOS: begin
                if (datos_valid) begin
                    datos_sig  = datos_in;
                    instr_sig  = ir;
                    paso_sig   = 1'b1;
                    pc_sig     = pc + AW'(1);
                    estado_sig = LEER;
                end
            end
            default: estado_sig = REPOSO;
        endcase
    end

endmodule

// File: tb/tb_secuenciador.sv
// Directed self-checking bench for secuenciador: program load, issue,
// bus-load handshake, conditional jumps, pc wrap, write gating and reset.
module tb_secuenciador;

    logic       clck = 1'b0;
    logic       rst_n;
    logic       inicio;
    logic       carga_we;
    logic [5:0] carga_dir;
    logic [7:0] carga_dato;
    logic [7:0] datos_in;
    logic       datos_valid;
    logic       datos_ready;
    logic       flag;
    logic [7:0] alContador;
    logic [7:0] instruccion;
    logic [7:0] datos;
    logic       paso;
    logic [5:0] pc;
    logic       ocupado;
    logic       detenido;

    int checks = 0;
    int errors = 0;

    logic [7:0] p_instr [32];
    logic [5:0] p_pc    [32];
    int         p_cyc   [32];
    int         npasos;
    int         halt_cyc;
    logic       tout;

    secuenciador #(.AW(6), .HALT_OP(8'hFF)) dut (
        .clck        (clck),
        .rst_n       (rst_n),
        .inicio      (inicio),
        .carga_we    (carga_we),
        .carga_dir   (carga_dir),
        .carga_dato  (carga_dato),
        .datos_in    (datos_in),
        .datos_valid (datos_valid),
        .datos_ready (datos_ready),
        .flag        (flag),
        .alContador  (alContador),
        .instruccion (instruccion),
        .datos       (datos),
        .paso        (paso),
        .pc          (pc),
        .ocupado     (ocupado),
        .detenido    (detenido)
    );

    always #5 clck = ~clck;

    task automatic load(input logic [5:0] dir, input logic [7:0] dato);
        carga_dir  = dir;
        carga_dato = dato;
        carga_we   = 1'b1;
        @(posedge clck); #1;
        carga_we   = 1'b0;
    endtask

    // Pulse inicio and record every paso until detenido; cycles are counted
    // from the edge that samples inicio. flag switches to f_rest after the
    // first paso, and an optional write is attempted during cycle wr_cycle.
    task automatic run_prog(input logic f_first, input logic f_rest, input int wr_cycle,
                            input logic [5:0] wr_dir, input logic [7:0] wr_dato);
        npasos   = 0;
        halt_cyc = -1;
        tout     = 1'b1;
        flag     = f_first;
        inicio   = 1'b1;
        @(posedge clck); #1;
        inicio   = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clck); #1;
            carga_we = 1'b0;
            if (cyc == wr_cycle) begin
                carga_dir  = wr_dir;
                carga_dato = wr_dato;
                carga_we   = 1'b1;
            end
            if (paso && npasos < 32) begin
                p_instr[npasos] = instruccion;
                p_pc[npasos]    = pc;
                p_cyc[npasos]   = cyc;
                npasos++;
                if (npasos == 1) flag = f_rest;
            end
            if (detenido) begin
                halt_cyc = cyc;
                tout     = 1'b0;
                break;
            end
        end
        carga_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (pc !== 6'd0) begin errors++; $display("[TB] FAIL reset_pc got %0d want 0", pc); end
        checks++; if ({instruccion, datos} !== 16'h0) begin errors++; $display("[TB] FAIL reset_buses got %h/%h want 00/00", instruccion, datos); end
        checks++; if ({paso, datos_ready, ocupado, detenido} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags got %b want 0000", {paso, datos_ready, ocupado, detenido}); end
        @(negedge clck); rst_n = 1'b1;
        @(posedge clck); #1;
    endtask

    task automatic test_basic();
        load(6'd0, 8'h05); load(6'd1, 8'h41); load(6'd2, 8'hFF);
        run_prog(1'b0, 1'b0, 0, 6'd0, 8'h00);
        checks++; if (tout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout got %b want 0", tout); end
        checks++; if (npasos !== 2) begin errors++; $display("[TB] FAIL basic_npasos got %0d want 2", npasos); end
        checks++; if (p_instr[0] !== 8'h05 || p_instr[1] !== 8'h41) begin errors++; $display("[TB] FAIL basic_instr got %h %h want 05 41", p_instr[0], p_instr[1]); end
        checks++; if (p_cyc[0] !== 2 || p_cyc[1] !== 4) begin errors++; $display("[TB] FAIL basic_paso_cyc got %0d %0d want 2 4", p_cyc[0], p_cyc[1]); end
        checks++; if (halt_cyc !== 6) begin errors++; $display("[TB] FAIL basic_halt_cyc got %0d want 6", halt_cyc); end
        checks++; if (pc !== 6'd2) begin errors++; $display("[TB] FAIL basic_halt_pc got %0d want 2", pc); end
        checks++; if (paso !== 1'b0 || ocupado !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got paso=%b ocupado=%b want 0 0", paso, ocupado); end
    endtask

    task automatic test_bus_load();
        int waited;
        load(6'd0, 8'hB0); load(6'd1, 8'hFF);
        flag        = 1'b0;
        datos_valid = 1'b0;
        inicio      = 1'b1;
        @(posedge clck); #1;
        inicio      = 1'b0;
        waited      = 0;
        while (!datos_ready && waited < 20) begin
            @(posedge clck); #1;
            waited++;
        end
        checks++; if (waited !== 2) begin errors++; $display("[TB] FAIL bus_ready_rise got %0d want 2", waited); end
        checks++; if (paso !== 1'b0) begin errors++; $display("[TB] FAIL bus_early_paso got %b want 0", paso); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clck); #1;
            checks++; if (datos_ready !== 1'b1 || paso !== 1'b0) begin errors++; $display("[TB] FAIL bus_wait%0d got ready=%b paso=%b want 1 0", i, datos_ready, paso); end
        end
        datos_in    = 8'h3C;
        datos_valid = 1'b1;
        @(posedge clck); #1;
        datos_valid = 1'b0;
        checks++; if (datos_ready !== 1'b0 || paso !== 1'b1) begin errors++; $display("[TB] FAIL bus_accept got ready=%b paso=%b want 0 1", datos_ready, paso); end
        checks++; if (datos !== 8'h3C || instruccion !== 8'hB0) begin errors++; $display("[TB] FAIL bus_values got %h/%h want 3C/B0", datos, instruccion); end
        checks++; if (pc !== 6'd1) begin errors++; $display("[TB] FAIL bus_pc got %0d want 1", pc); end
        @(posedge clck); #1;
        checks++; if (paso !== 1'b0) begin errors++; $display("[TB] FAIL bus_single_paso got %b want 0", paso); end
        waited = 0;
        while (!detenido && waited < 20) begin
            @(posedge clck); #1;
            waited++;
        end
        checks++; if (detenido !== 1'b1 || pc !== 6'd1) begin errors++; $display("[TB] FAIL bus_halt got det=%b pc=%0d want 1 1", detenido, pc); end
    endtask

    task automatic test_conditional();
        for (int a = 0; a < 4; a++) load(6'(a), 8'h00);
        load(6'd4, 8'hC0); load(6'd5, 8'hFF); load(6'd16, 8'hFF);
        alContador = 8'h10;
        run_prog(1'b1, 1'b1, 0, 6'd0, 8'h00);
        checks++; if (npasos !== 5 || p_instr[4] !== 8'hC0) begin errors++; $display("[TB] FAIL cond_taken_n got %0d/%h want 5/C0", npasos, p_instr[4]); end
        checks++; if (p_pc[4] !== 6'd16 || pc !== 6'd16) begin errors++; $display("[TB] FAIL cond_taken_pc got %0d/%0d want 16/16", p_pc[4], pc); end
        checks++; if (halt_cyc !== 12) begin errors++; $display("[TB] FAIL cond_taken_cyc got %0d want 12", halt_cyc); end
        run_prog(1'b0, 1'b0, 0, 6'd0, 8'h00);
        checks++; if (p_pc[4] !== 6'd5 || pc !== 6'd5) begin errors++; $display("[TB] FAIL cond_not_taken_pc got %0d/%0d want 5/5", p_pc[4], pc); end
        checks++; if (datos !== 8'h3C) begin errors++; $display("[TB] FAIL datos_hold got %h want 3C", datos); end
    endtask

    task automatic test_wrap();
        load(6'd0, 8'hC0); load(6'd1, 8'hFF); load(6'd62, 8'h01); load(6'd63, 8'h02);
        alContador = 8'd62;
        run_prog(1'b1, 1'b0, 0, 6'd0, 8'h00);
        checks++; if (npasos !== 4) begin errors++; $display("[TB] FAIL wrap_npasos got %0d want 4", npasos); end
        checks++; if (p_pc[0] !== 6'd62 || p_pc[1] !== 6'd63 || p_pc[2] !== 6'd0) begin errors++; $display("[TB] FAIL wrap_pc got %0d %0d %0d want 62 63 0", p_pc[0], p_pc[1], p_pc[2]); end
        checks++; if (p_instr[2] !== 8'h02 || pc !== 6'd1) begin errors++; $display("[TB] FAIL wrap_halt got %h/%0d want 02/1", p_instr[2], pc); end
    endtask

    task automatic test_write_gating();
        load(6'd0, 8'h00); load(6'd1, 8'h00); load(6'd2, 8'h00); load(6'd3, 8'hFF);
        run_prog(1'b0, 1'b0, 1, 6'd1, 8'hFF);
        checks++; if (npasos !== 3 || pc !== 6'd3) begin errors++; $display("[TB] FAIL busy_write got n=%0d pc=%0d want 3 3", npasos, pc); end
        load(6'd1, 8'hFF);
        run_prog(1'b0, 1'b0, 0, 6'd0, 8'h00);
        checks++; if (npasos !== 1 || pc !== 6'd1) begin errors++; $display("[TB] FAIL idle_write got n=%0d pc=%0d want 1 1", npasos, pc); end
    endtask

    task automatic test_reset_mid();
        int waited;
        load(6'd0, 8'hB0); load(6'd1, 8'hFF);
        datos_valid = 1'b0;
        inicio      = 1'b1;
        @(posedge clck); #1;
        inicio      = 1'b0;
        waited      = 0;
        while (!datos_ready && waited < 20) begin
            @(posedge clck); #1;
            waited++;
        end
        checks++; if (datos_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", datos_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({paso, datos_ready, ocupado, detenido} !== 4'b0 || pc !== 6'd0) begin errors++; $display("[TB] FAIL mid_reset_flags got %b pc=%0d want 0000 0", {paso, datos_ready, ocupado, detenido}, pc); end
        checks++; if (datos !== 8'h00 || instruccion !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_buses got %h/%h want 00/00", datos, instruccion); end
        @(negedge clck); rst_n = 1'b1;
        @(posedge clck); #1;
        load(6'd0, 8'hFF);
        run_prog(1'b0, 1'b0, 0, 6'd0, 8'h00);
        checks++; if (npasos !== 0 || halt_cyc !== 2 || pc !== 6'd0) begin errors++; $display("[TB] FAIL post_reset_run got n=%0d cyc=%0d pc=%0d want 0 2 0", npasos, halt_cyc, pc); end
    endtask

    initial begin
        rst_n       = 1'b0;
        inicio      = 1'b0;
        carga_we    = 1'b0;
        carga_dir   = '0;
        carga_dato  = '0;
        datos_in    = '0;
        datos_valid = 1'b0;
        flag        = 1'b0;
        alContador  = '0;
        test_reset();
        test_basic();
        test_bus_load();
        test_conditional();
        test_wrap();
        test_write_gating();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
